and_scoreboard: RTL and testbench
=================================

Name: and_scoreboard

Overview:
- Synthesizable response checker for the AND-gate testbench: the receive and compare end of the stimulus path.
- The stimulus side pushes each (a, b) pair as it drives the DUT. The block stores the expected result a&b in an in-order FIFO.
- Each DUT response c pops one entry and is compared against it.
- Keeps pass/error counts, captures the first mismatch, runs a watchdog, and raises a final pass/done verdict that a testcase polls instead of hand-coding an error call.

Parameters:
- WIDTH, 8, bit width of a, b, c.
- DEPTH, 8, expected-value FIFO depth; power of two, 2..64.
- NUM_CHECKS, 16, number of responses to compare before done; 1..65535.
- TIMEOUT, 1000, max idle cycles in RUN with no response before abort; 1..65535.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; IDLE->RUN; ignored in other states.
- stim_valid  in  1  stimulus (a, b) applied to DUT this cycle.
- a  in  WIDTH  stimulus operand a.
- b  in  WIDTH  stimulus operand b.
- rsp_valid  in  1  DUT response valid this cycle.
- c  in  WIDTH  DUT response.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; sticky until rst.
- pass  out  1  done & err_count==0 & !overflow & !timeout.
- mismatch  out  1  one-cycle pulse on each failed compare or unexpected response.
- err_count  out  16  failed compares plus unexpected responses; saturates at 0xFFFF.
- chk_count  out  16  responses consumed in RUN.
- overflow  out  1  sticky: stimulus arrived with FIFO full and no pop.
- timeout  out  1  sticky: watchdog expired.
- first_exp  out  WIDTH  expected value of first mismatch.
- first_got  out  WIDTH  c of first mismatch.

Behaviour:
Reset:
- State = IDLE; FIFO empty.
- All outputs 0, including first_exp/first_got.
- Reset mid-RUN discards all FIFO contents, counts and flags.

States:
- IDLE: ignores stim/rsp; start -> RUN and clears counters, flags and FIFO.
- RUN: push/pop/compare active. chk_count reaching NUM_CHECKS -> DONE. Watchdog expiry -> DONE with timeout=1.
- DONE: terminal; ignores all inputs; outputs frozen. Only rst leaves DONE.

Push:
- In RUN, stim_valid writes (a & b) to FIFO tail, registered.
- If the FIFO is full and rsp_valid is low the same cycle: entry dropped, overflow=1, not counted as an error.

Pop and compare, in RUN on rsp_valid:
- FIFO non-empty: pop head; compare against c in the same cycle.
  - Equal: chk_count+1.
  - Unequal: chk_count+1, err_count+1, mismatch=1 next cycle.
- FIFO empty: unexpected response; chk_count+1, err_count+1, mismatch=1. No bypass from a same-cycle push.

Simultaneous push and pop:
- Both legal, including at full (pop frees the slot; no overflow).
- Occupancy is unchanged.

First-error capture:
- On the first error after start, latch expected (0 for an unexpected response) and c into first_exp/first_got.
- Later errors do not update the capture.

Watchdog:
- Counts RUN cycles without rsp_valid; reset to 0 on every rsp_valid.
- Expires when the count == TIMEOUT.

Latency:
- All status outputs registered: visible 1 cycle after the causing edge.
- done asserts the cycle after the final compare.
- A compare on the final response is reflected in err_count and pass together.

Counter limits:
- chk_count never exceeds NUM_CHECKS.
- err_count saturates at 0xFFFF.

Test Plan:
1. start; 16 stim/rsp pairs, rsp 1 cycle after stim, a=b=8'hFF..., c=a&b -> done=1, pass=1, err_count=0, chk_count=16.
2. Same as 1 but response #5 is c=8'h0F, expected 8'h03 -> mismatch pulse once, err_count=1, first_exp=03, first_got=0F, pass=0.
3. rsp_valid with c=8'hAA before any stimulus -> err_count=1, first_exp=00, first_got=AA.
4. DEPTH=8: 9 stims with no rsp -> overflow=1. Then a 9th stim coincident with rsp at full -> no overflow in the separate run.
5. TIMEOUT=20: start, 3 stims, 2 rsps, then idle -> done and timeout=1 exactly 21 cycles after the last rsp; pass=0, chk_count=2.
6. Assert rst at chk_count=7 mid-RUN -> next cycle all outputs 0, state IDLE; a following start plus 16 clean pairs gives pass=1.

Source files
------------

// File: rtl/and_scoreboard_if.sv
// -----------------------------------------------------------------------------
// and_scoreboard_if
//   Bundles the stimulus and response sides of the AND-gate checking path.
//
//   Signals:
//     stim_valid  stimulus (a, b) applied to the AND gate this cycle
//     a, b        stimulus operands
//     rsp_valid   AND-gate response valid this cycle
//     c           AND-gate response
//
//   Handshake: both streams are valid-only and have no ready signal. A beat
//   transfers on every rising clk edge where its valid is high. The receiver
//   cannot stall either stream, so the sender never waits.
//
//   Modports:
//     master  the side that drives stimulus and responses (testbench / DUT wrapper)
//     slave   the scoreboard consuming both streams
// -----------------------------------------------------------------------------
interface and_scoreboard_if #(
  parameter int WIDTH = 8
);
  logic             stim_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rsp_valid;
  logic [WIDTH-1:0] c;

  modport master (output stim_valid, a, b, rsp_valid, c);
  modport slave  (input  stim_valid, a, b, rsp_valid, c);
endinterface

// File: rtl/and_scoreboard.sv
// -----------------------------------------------------------------------------
// and_scoreboard
//   Receive-and-compare end of the AND-gate stimulus path. Each stimulus (a, b)
//   pushes a & b into an in-order FIFO. Each response c pops one entry and is
//   compared against it. The block keeps pass/error counts, captures the first
//   mismatch and runs an idle watchdog. It then raises a sticky done/pass
//   verdict for the testcase to poll.
//
//   Ports:
//     clk, rst     rising-edge clock, synchronous active-high reset
//     start        one-cycle pulse, IDLE -> RUN (ignored elsewhere)
//     bus          and_scoreboard_if.slave: stim_valid/a/b, rsp_valid/c
//     busy         high in RUN
//     done         high in DONE, sticky until rst
//     pass         done with no errors, no overflow and no timeout
//     mismatch     one-cycle pulse after each failed or unexpected response
//     err_count    failed compares + unexpected responses (saturating)
//     chk_count    responses consumed in RUN (stops at NUM_CHECKS)
//     overflow     sticky: stimulus dropped because the FIFO was full
//     timeout      sticky: watchdog expired
//     first_exp    expected value of the first error (0 if unexpected)
//     first_got    response value of the first error
//     state_dbg    current FSM state (IDLE=0, RUN=1, DONE=2)
// -----------------------------------------------------------------------------
module and_scoreboard #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int NUM_CHECKS = 16,
  parameter int TIMEOUT    = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  and_scoreboard_if.slave  bus,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [15:0]      err_count,
  output logic [15:0]      chk_count,
  output logic             overflow,
  output logic             timeout,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_got,
  output logic [1:0]       state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [15:0]      wd_cnt;

  logic             run;
  logic             full;
  logic             empty;
  logic             wd_expire;
  logic             rsp_fire;
  logic             stim_fire;
  logic             pop;
  logic             push;
  logic             drop;
  logic [WIDTH-1:0] exp_val;
  logic             err_event;
  logic [15:0]      chk_next;
  logic             final_chk;

  // Datapath decode. Once the watchdog has expired, that cycle is spent
  // leaving RUN and any stimulus or response seen in it is ignored.
  always_comb begin
    run       = (state == S_RUN);
    full      = (count == CW'(DEPTH));
    empty     = (count == '0);
    wd_expire = run && (wd_cnt == 16'(TIMEOUT));
    rsp_fire  = run && !wd_expire && bus.rsp_valid;
    stim_fire = run && !wd_expire && bus.stim_valid;
    pop       = rsp_fire && !empty;
    // A pop in the same cycle frees the slot, so a push at full is still legal.
    push      = stim_fire && (!full || pop);
    drop      = stim_fire && full && !pop;
    // An empty FIFO reads as 0. A same-cycle push is never forwarded.
    exp_val   = empty ? '0 : mem[rd_ptr];
    err_event = rsp_fire && (empty || (mem[rd_ptr] != bus.c));
    chk_next  = chk_count + 16'd1;
    final_chk = rsp_fire && (chk_next == 16'(NUM_CHECKS));
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // FSM next-state
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_RUN;
      S_RUN:  if (wd_expire || final_chk) state_next = S_DONE;
      S_DONE: state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // FIFO storage. It needs no reset because the pointers and count define
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.a & bus.b;
  end

  // Counters, flags, pointers and first-error capture
  always_ff @(posedge clk) begin
    if (rst || (state == S_IDLE && start)) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wd_cnt    <= '0;
      mismatch  <= 1'b0;
      err_count <= '0;
      chk_count <= '0;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
      first_exp <= '0;
      first_got <= '0;
    end else begin
      mismatch <= err_event;

      if (run && !wd_expire) begin
        wd_cnt <= bus.rsp_valid ? 16'd0 : wd_cnt + 16'd1;
      end
      if (wd_expire) timeout <= 1'b1;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      if (drop) overflow <= 1'b1;

      if (rsp_fire) chk_count <= chk_next;

      if (err_event) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        // err_count is still zero only until the first error after start.
        if (err_count == 16'd0) begin
          first_exp <= exp_val;
          first_got <= bus.c;
        end
      end
    end
  end

  always_comb begin
    busy      = (state == S_RUN);
    done      = (state == S_DONE);
    pass      = done && (err_count == 16'd0) && !overflow && !timeout;
    state_dbg = state;
  end

endmodule

// File: tb/tb_and_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_and_scoreboard
//   Drives and_scoreboard with stimulus/response streams and tracks the
//   expected FIFO contents in exp_q. It checks every status output against a
//   cycle-level model after each clock.
// -----------------------------------------------------------------------------
module tb_and_scoreboard;

  localparam int WIDTH      = 8;
  localparam int DEPTH      = 8;
  localparam int NUM_CHECKS = 16;
  localparam int TIMEOUT    = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  and_scoreboard_if #(.WIDTH(WIDTH)) bus ();

  logic             busy, done, pass, mismatch, overflow, timeout;
  logic [15:0]      err_count, chk_count;
  logic [WIDTH-1:0] first_exp, first_got;
  logic [1:0]       state_dbg;

  and_scoreboard #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CHECKS(NUM_CHECKS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .err_count(err_count), .chk_count(chk_count),
    .overflow(overflow), .timeout(timeout),
    .first_exp(first_exp), .first_got(first_got), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  logic [WIDTH-1:0] exp_q[$];   // model of the DUT expected-value FIFO
  logic [WIDTH-1:0] pend_q[$];  // correct AND-gate answers awaiting response
  int               m_state;    // 0 idle, 1 run, 2 done
  int               m_wd;
  int               m_chk, m_err;
  logic             m_ovf, m_tmo, m_mm;
  logic [WIDTH-1:0] m_fe, m_fg;
  int               mm_seen;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend_q.delete();
    m_wd = 0; m_chk = 0; m_err = 0;
    m_ovf = 0; m_tmo = 0; m_mm = 0;
    m_fe = '0; m_fg = '0;
    mm_seen = 0;
  endtask

  task automatic model_err(input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] g);
    m_mm = 1'b1;
    if (m_err == 0) begin
      m_fe = e;
      m_fg = g;
    end
    if (m_err < 16'hFFFF) m_err++;
  endtask

  // Effect of one clock edge on the model, given the inputs presented at it.
  task automatic model_edge(input logic sv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic rv, input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] e;
    m_mm = 1'b0;
    if (m_state == 1) begin
      if (m_wd == TIMEOUT) begin
        m_tmo   = 1'b1;
        m_state = 2;
      end else begin
        m_wd = rv ? 0 : m_wd + 1;
        if (rv) begin
          m_chk++;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e != c) model_err(e, c);
          end else begin
            model_err('0, c);
          end
        end
        if (sv) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(a & b);
          else                      m_ovf = 1'b1;
        end
        if (m_chk == NUM_CHECKS) m_state = 2;
      end
    end
  endtask

  task automatic check_status();
    logic m_pass;
    m_pass = (m_state == 2) && (m_err == 0) && !m_ovf && !m_tmo;
    check_val("busy",      busy,      m_state == 1);
    check_val("done",      done,      m_state == 2);
    check_val("pass",      pass,      m_pass);
    check_val("mismatch",  mismatch,  m_mm);
    check_val("err_count", err_count, m_err);
    check_val("chk_count", chk_count, m_chk);
    check_val("overflow",  overflow,  m_ovf);
    check_val("timeout",   timeout,   m_tmo);
    check_val("first_exp", first_exp, m_fe);
    check_val("first_got", first_got, m_fg);
    if (mismatch) mm_seen++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic sv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic rv, input logic [WIDTH-1:0] c);
    bus.stim_valid = sv;
    bus.a          = a;
    bus.b          = b;
    bus.rsp_valid  = rv;
    bus.c          = c;
    @(posedge clk);
    model_edge(sv, a, b, rv, c);
    #1;
    check_status();
    bus.stim_valid = 1'b0;
    bus.rsp_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    bus.stim_valid = 1'b0;
    bus.rsp_valid  = 1'b0;
    @(posedge clk);
    m_state = 0;
    model_reset();
    #1;
    check_status();
    check_val("state_idle", state_dbg, 0);
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    if (m_state == 0) begin
      model_reset();
      m_state = 1;
    end
    #1;
    start = 1'b0;
    check_status();
  endtask

  // n stimulus pairs, each response one cycle after its stimulus. Pair
  // bad_idx uses a=03, b=07 and gets response bad_c. Stops early once
  // chk_count reaches stop_chk (when stop_chk > 0).
  task automatic run_pairs(input int n, input int bad_idx, input logic [WIDTH-1:0] bad_c,
                           input int stop_chk);
    logic             sv, rv;
    logic [WIDTH-1:0] a, b, c;
    for (int i = 0; i <= n; i++) begin
      sv = (i < n);
      a  = WIDTH'($urandom_range(0, 255));
      b  = WIDTH'($urandom_range(0, 255));
      if (i == bad_idx) begin
        a = 8'h03;
        b = 8'h07;
      end
      rv = (i > 0) && (pend_q.size() > 0);
      c  = '0;
      if (rv) begin
        c = pend_q.pop_front();
        if (i - 1 == bad_idx) c = bad_c;
      end
      if (sv) pend_q.push_back(a & b);
      drive_cycle(sv, a, b, rv, c);
      if (stop_chk > 0 && m_chk == stop_chk) break;
    end
  endtask

  // ---------------- tests ----------------
  initial begin
    int k;
    bus.stim_valid = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0;
    m_state = 0;
    model_reset();

    // 1: clean run
    do_reset();
    do_start();
    run_pairs(NUM_CHECKS, -1, '0, 0);
    check_val("t1_done", done, 1);
    check_val("t1_pass", pass, 1);
    check_val("t1_err",  err_count, 0);
    check_val("t1_chk",  chk_count, 16);

    // 2: response #5 wrong
    do_reset();
    do_start();
    run_pairs(NUM_CHECKS, 4, 8'h0F, 0);
    check_val("t2_mm_pulses", mm_seen, 1);
    check_val("t2_err",       err_count, 1);
    check_val("t2_first_exp", first_exp, 8'h03);
    check_val("t2_first_got", first_got, 8'h0F);
    check_val("t2_pass",      pass, 0);
    check_val("t2_done",      done, 1);

    // 3: unexpected response before any stimulus
    do_reset();
    do_start();
    drive_cycle(1'b0, '0, '0, 1'b1, 8'hAA);
    drive_cycle(1'b0, '0, '0, 1'b0, '0);
    check_val("t3_err",       err_count, 1);
    check_val("t3_first_exp", first_exp, 8'h00);
    check_val("t3_first_got", first_got, 8'hAA);

    // 4a: overflow with nine stimuli and no response
    do_reset();
    do_start();
    for (int i = 0; i < DEPTH + 1; i++)
      drive_cycle(1'b1, WIDTH'(i), 8'hFF, 1'b0, '0);
    check_val("t4_overflow", overflow, 1);
    check_val("t4_err",      err_count, 0);

    // 4b: ninth stimulus coincident with a response at full
    do_reset();
    do_start();
    for (int i = 0; i < DEPTH; i++)
      drive_cycle(1'b1, WIDTH'(i + 1), 8'hFF, 1'b0, '0);
    drive_cycle(1'b1, 8'h5A, 8'h0F, 1'b1, 8'h01);
    check_val("t4_no_overflow", overflow, 0);
    check_val("t4_chk",         chk_count, 1);
    check_val("t4_err_b",       err_count, 0);

    // 5: watchdog
    do_reset();
    do_start();
    drive_cycle(1'b1, 8'h11, 8'h13, 1'b0, '0);
    drive_cycle(1'b1, 8'h22, 8'h26, 1'b0, '0);
    drive_cycle(1'b1, 8'h44, 8'h4C, 1'b0, '0);
    drive_cycle(1'b0, '0, '0, 1'b1, 8'h11);
    drive_cycle(1'b0, '0, '0, 1'b1, 8'h22);
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, '0);
      if (done) begin
        k = i;
        break;
      end
    end
    check_val("t5_latency", k, TIMEOUT + 1);
    check_val("t5_timeout", timeout, 1);
    check_val("t5_pass",    pass, 0);
    check_val("t5_chk",     chk_count, 2);

    // 6: reset mid-run, then a clean run
    do_reset();
    do_start();
    run_pairs(NUM_CHECKS, -1, '0, 7);
    check_val("t6_chk_before_rst", chk_count, 7);
    do_reset();
    check_val("t6_busy_after_rst", busy, 0);
    check_val("t6_chk_after_rst",  chk_count, 0);
    do_start();
    run_pairs(NUM_CHECKS, -1, '0, 0);
    check_val("t6_pass", pass, 1);
    check_val("t6_chk",  chk_count, 16);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
